// File: rtl/led_frame_shifter.sv
// led_frame_shifter
// Per-LED staging buffer plus a frame-wide shift register. The shift register
// streams the frame MSB-first to the LED bit-timing encoder over a valid/ready
// handshake. Supports one-shot and continuous-repeat modes.
module led_frame_shifter #(
    parameter int NUM_LEDS     = 5,
    parameter int BITS_PER_LED = 24,
    parameter int AW           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [BITS_PER_LED-1:0] wr_data,
    input  logic                    start,
    input  logic                    repeat_mode,
    input  logic                    stop,
    output logic                    bit_out,
    output logic                    bit_valid,
    input  logic                    bit_ready,
    output logic                    frame_end,
    output logic                    busy,
    output logic                    done
);

    localparam int TOTAL = NUM_LEDS * BITS_PER_LED;
    localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [TOTAL-1:0]        shift_q, shift_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    stop_q, stop_d;
    logic [BITS_PER_LED-1:0] stage_q [NUM_LEDS];
    logic [TOTAL-1:0]        frame_w;
    logic                    hs;
    logic                    last_bit;

    // Staging buffer: out-of-range addresses match no entry and are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LEDS; i++) stage_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (wr_en && (wr_addr == AW'(i))) stage_q[i] <= wr_data;
            end
        end
    end

    // Flatten the buffer so LED 0 lands in the MSBs and is sent first.
    always_comb begin
        frame_w = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            frame_w[TOTAL-1-i*BITS_PER_LED -: BITS_PER_LED] = stage_q[i];
        end
    end

    assign bit_valid = (state_q == S_SHIFT);
    assign bit_out   = bit_valid & shift_q[TOTAL-1];
    assign last_bit  = (cnt_q == CW'(TOTAL-1));
    assign frame_end = bit_valid & last_bit;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign hs        = bit_valid & bit_ready;

    // Next-state logic for the FSM, shift register, bit counter and stop latch.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        stop_d  = stop_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                // frame_w reflects register contents, so a same-cycle write
                // is not part of this snapshot.
                shift_d = frame_w;
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (hs) begin
                    shift_d = shift_q << 1;
                    if (last_bit) begin
                        cnt_d = '0;
                        // A stop arriving with the last bit also ends the sequence.
                        if (repeat_mode && !(stop_q || stop)) state_d = S_LOAD;
                        else                                  state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (busy && stop) stop_d = 1'b1;
        if (state_d == S_IDLE) stop_d = 1'b0;
    end

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
        end
    end

endmodule

// File: tb/tb_led_frame_shifter.sv
// Testbench for led_frame_shifter: directed frames against hand-built
// expected bit streams, on a 5-LED instance and a 1-LED instance.
module tb_led_frame_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [23:0] wr_data;
    logic        start, repeat_mode, stop, bit_ready;
    logic        bit_out, bit_valid, frame_end, busy, done;

    logic        b_wr_en;
    logic [0:0]  b_wr_addr;
    logic [23:0] b_wr_data;
    logic        b_start, b_bit_ready;
    logic        b_bit_out, b_bit_valid, b_frame_end, b_busy, b_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [119:0] frame_a, frame_b, frame_z;

    always #5 clk = ~clk;

    led_frame_shifter #(.NUM_LEDS(5), .BITS_PER_LED(24)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .repeat_mode(repeat_mode), .stop(stop),
        .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .frame_end(frame_end), .busy(busy), .done(done)
    );

    led_frame_shifter #(.NUM_LEDS(1), .BITS_PER_LED(24)) dut1 (
        .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .start(b_start), .repeat_mode(1'b0), .stop(1'b0),
        .bit_out(b_bit_out), .bit_valid(b_bit_valid), .bit_ready(b_bit_ready),
        .frame_end(b_frame_end), .busy(b_busy), .done(b_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_led(input logic [2:0] addr, input logic [23:0] data);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Start a frame and follow it until done. ready_pat 0 = always ready,
    // 1 = ready on odd cycles only. Thresholds < 0 disable the mid-run actions.
    task automatic run_frames(input int ready_pat, input logic [119:0] exp0, input logic [119:0] exp1,
                              input int nframes, input int exp_done_cyc, input int wr_at_hs,
                              input logic [23:0] wr_val, input int stop_at_hs, input int start_again_hs);
        int cyc, hs_total, f, b, loads, bad;
        logic prev_stall, prev_bit, prev_fe, got_done;
        logic [119:0] cur;
        cyc = 0; hs_total = 0; f = 0; b = 0; loads = 0;
        prev_stall = 1'b0; prev_bit = 1'b0; prev_fe = 1'b0; got_done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        while (cyc < 1000) begin
            @(negedge clk);
            cyc++;
            start   = (hs_total == start_again_hs);
            wr_en   = (hs_total == wr_at_hs);
            wr_addr = 3'd2;
            wr_data = wr_val;
            stop    = (hs_total == stop_at_hs);
            if (cyc == 1) check_eq("latency_load", {30'd0, busy, bit_valid}, 32'h2);
            if (cyc == 2) check_eq("latency_first_valid", {31'd0, bit_valid}, 32'h1);
            if (prev_stall) begin
                check_eq("stall_hold", {29'd0, bit_valid, bit_out, frame_end}, {29'd0, 1'b1, prev_bit, prev_fe});
            end
            bit_ready = (ready_pat == 0) ? 1'b1 : cyc[0];
            if (busy && !bit_valid && !done) loads++;
            prev_stall = bit_valid && !bit_ready;
            prev_bit = bit_out;
            prev_fe = frame_end;
            if (bit_valid && bit_ready) begin
                cur = (f == 0) ? exp0 : exp1;
                check_eq("stream_bit", {31'd0, bit_out}, {31'd0, cur[119-b]});
                check_eq("frame_end", {31'd0, frame_end}, {31'd0, (b == 119)});
                hs_total++;
                b++;
                if (b == 120) begin b = 0; f++; end
            end
            if (done) begin
                got_done = 1'b1;
                check_eq("handshakes_at_done", hs_total, nframes * 120);
                check_eq("load_cycles", loads, nframes);
                if (exp_done_cyc >= 0) check_eq("done_cycle", cyc, exp_done_cyc);
                break;
            end
        end
        check_eq("done_seen", {31'd0, got_done}, 32'h1);
        start = 1'b0; wr_en = 1'b0; stop = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy || done || bit_valid) bad++;
        end
        check_eq("idle_after_done", bad, 0);
    endtask

    initial begin
        int hs, bad;
        logic got;
        logic [23:0] a5;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; repeat_mode = 1'b0; stop = 1'b0; bit_ready = 1'b0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_start = 1'b0; b_bit_ready = 1'b0;
        frame_a = {24'hFF0000, 24'h000001, 24'h000001, 24'h000001, 24'h000001};
        frame_b = {24'hFF0000, 24'h000001, 24'h123456, 24'h000001, 24'h000001};
        frame_z = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("reset_outputs", {27'd0, bit_out, bit_valid, frame_end, busy, done}, 32'h0);
        check_eq("reset_outputs_1led", {27'd0, b_bit_out, b_bit_valid, b_frame_end, b_busy, b_done}, 32'h0);

        // One-shot frame, ready held high.
        write_led(3'd0, 24'hFF0000);
        for (int i = 1; i < 5; i++) write_led(3'(i), 24'h000001);
        run_frames(0, frame_a, frame_a, 1, 122, -1, 24'h0, -1, -1);

        // Same frame with ready toggling.
        run_frames(1, frame_a, frame_a, 1, -1, -1, 24'h0, -1, -1);

        // Repeat mode, LED2 rewritten during frame 1, stop during frame 2.
        repeat_mode = 1'b1;
        run_frames(0, frame_a, frame_b, 2, -1, 30, 24'h123456, 150, -1);
        repeat_mode = 1'b0;

        // Out-of-range write is dropped; start while busy is ignored.
        write_led(3'd7, 24'hFFFFFF);
        run_frames(0, frame_b, frame_b, 1, 122, -1, 24'h0, -1, 10);

        // Reset in the middle of a frame.
        @(negedge clk);
        start = 1'b1; bit_ready = 1'b1; hs = 0;
        for (int i = 0; i < 200 && hs < 50; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (bit_valid && bit_ready) hs++;
        end
        check_eq("reached_bit50", hs, 50);
        reset = 1'b1;
        @(negedge clk);
        check_eq("reset_abort", {28'd0, bit_valid, busy, done, bit_out}, 32'h0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        check_eq("no_done_after_reset", bad, 0);
        run_frames(0, frame_z, frame_z, 1, 122, -1, 24'h0, -1, -1);

        // Single-LED instance.
        a5 = 24'hA5A5A5;
        @(negedge clk);
        b_wr_en = 1'b1; b_wr_addr = 1'b0; b_wr_data = a5;
        @(negedge clk);
        b_wr_en = 1'b0; b_start = 1'b1; b_bit_ready = 1'b1;
        hs = 0; got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            b_start = 1'b0;
            if (b_bit_valid && b_bit_ready) begin
                check_eq("led1_bit", {31'd0, b_bit_out}, {31'd0, a5[23-hs]});
                check_eq("led1_frame_end", {31'd0, b_frame_end}, {31'd0, (hs == 23)});
                hs++;
            end
            if (b_done) begin got = 1'b1; break; end
        end
        check_eq("led1_done", {31'd0, got}, 32'h1);
        check_eq("led1_bits", hs, 24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
